countdown_timer: RTL and testbench
==================================

// Module: countdown_timer
// PURPOSE
//   Down-counting timer: loads a start value, decrements once per prescaled tick while running,
//   flags expiry on reaching zero, optionally auto-reloads. Complements the up-counting stopwatch
//   in the timer subsystem; drives timeouts/periodic events for control FSMs.
// PARAMETERS
//   DATA_WIDTH  16  width of load_value/count
//   PRESCALE    1   clk cycles per decrement tick (>=1; 1 = decrement every cycle)
// PORTS
//   clk          in   1           clock, rising edge
//   reset        in   1           synchronous, active-high
//   load         in   1           capture load_value into count and reload register
//   load_value   in   DATA_WIDTH  value captured on load
//   start        in   1           begin/resume counting
//   stop         in   1           pause counting (count held)
//   auto_reload  in   1           on expiry reload from reload register and keep running
//   count        out  DATA_WIDTH  current remaining count
//   running      out  1           state==RUN
//   done         out  1           state==DONE (expired, no auto-reload)
//   expired      out  1           one-cycle pulse per expiry
// BEHAVIOUR
//   - reset: count=0, reload_reg=0, state=IDLE, prescale cnt=0, running=0, done=0, expired=0.
//   - States: IDLE, RUN, PAUSE, DONE. All outputs registered or decoded from registered state.
//   - Priority per edge: reset > load > stop > start > tick.
//   - load (any state): count<=load_value, reload_reg<=load_value, state<=IDLE, no expired pulse.
//     load and start same cycle: load wins; start ignored.
//   - start in IDLE/PAUSE with count!=0 -> RUN. start with count==0 ignored. start in RUN: no-op.
//     start in DONE ignored; a new load is required.
//   - stop in RUN -> PAUSE, no decrement on that edge; stop elsewhere no-op. stop+start same
//     cycle: stop wins.
//   - Prescaler: counter 0..PRESCALE-1, advances only in RUN, cleared whenever state!=RUN.
//     tick = RUN && presc==PRESCALE-1. PRESCALE=1 -> tick every RUN cycle.
//   - Latency: start sampled at edge E0 -> running=1 after E0; first decrement at edge E(PRESCALE).
//   - On tick with count>1: count<=count-1.
//   - On tick with count==1: expired<=1 for exactly one cycle; then
//       auto_reload=1 and reload_reg!=0: count<=reload_reg, stay RUN (period = reload_reg ticks);
//       otherwise: count<=0, state<=DONE.
//   - auto_reload sampled only at the expiry tick; may change freely at other times.
//   - count never wraps below 0; no decrement when count==0.
//   - reset mid-run: returns to reset values on that edge, pending expiry discarded.
// STRUCTURE
//   - timer_pkg: typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} timer_state_t; shared
//     with stopwatch block.
//   - Sub-module tick_prescaler (#(PRESCALE); clk, reset, enable, tick): counter cleared when
//     enable=0; constant-1 output path when PRESCALE==1.
//   - Top: state register, count/reload registers, expired pulse register.
// TESTING
//   1. load 5, start, PRESCALE=1 -> count 4,3,2,1,0 on next 5 edges; expired 1 cycle with
//      count==0; done=1, running=0.
//   2. load 3, auto_reload=1, start -> count 2,1,3,2,1,3...; expired every 3 cycles; never DONE.
//   3. PRESCALE=4, load 2, start -> first decrement 4 edges after start; expiry at edge 8.
//   4. load 10, start, stop after 3 edges -> count holds 7; start -> resumes 6; stop+start same
//      cycle -> PAUSE.
//   5. load 0, start -> stays IDLE, no expired; load 4 + start same cycle -> count=4, IDLE.
//   6. reset while RUN at count 1 -> count 0, IDLE, no expired pulse; start in DONE ignored.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared timer-subsystem types: state encoding used by the countdown timer and the stopwatch.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_t;

  localparam int unsigned TIMER_DEFAULT_WIDTH = 16;

  // Counting may only (re)start from a stopped, non-expired state
  function automatic logic can_start(timer_state_t s);
    return (s == IDLE) || (s == PAUSE);
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle of the countdown timer; master drives controls, slave is the timer.
interface countdown_timer_if #(
  parameter int unsigned DATA_WIDTH = 16
);

  logic                  load;
  logic [DATA_WIDTH-1:0] load_value;
  logic                  start;
  logic                  stop;
  logic                  auto_reload;
  logic [DATA_WIDTH-1:0] count;
  logic                  running;
  logic                  done;
  logic                  expired;

  modport master (
    output load, load_value, start, stop, auto_reload,
    input  count, running, done, expired
  );

  modport slave (
    input  load, load_value, start, stop, auto_reload,
    output count, running, done, expired
  );

endinterface

// File: rtl/tick_prescaler.sv
// Emits one tick every PRESCALE enabled cycles; the phase restarts whenever enable drops.
module tick_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  generate
    if (PRESCALE <= 1) begin : g_bypass
      // Every enabled cycle is a tick; no counter state needed
      logic unused_ctl;
      assign unused_ctl = clk ^ reset;
      assign tick       = enable;
    end else begin : g_count
      localparam int unsigned CNT_W = $clog2(PRESCALE);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

      logic [CNT_W-1:0] cnt_q;

      always_ff @(posedge clk) begin
        if (reset || !enable) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end

      assign tick = enable && (cnt_q == CNT_LAST);
    end
  endgenerate

endmodule

// File: rtl/countdown_timer.sv
// Down-counting timer with prescaled decrement, pause/resume, expiry pulse and optional auto-reload.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = TIMER_DEFAULT_WIDTH,
  parameter int unsigned PRESCALE   = 1
) (
  input  logic             clk,
  input  logic             reset,
  countdown_timer_if.slave bus
);

  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  timer_state_t          state_q, state_next;
  logic [DATA_WIDTH-1:0] count_q, count_next;
  logic [DATA_WIDTH-1:0] reload_q, reload_next;
  logic                  expired_q, expired_next;
  logic                  running_q, running_next;
  logic                  done_q, done_next;
  logic                  tick;
  logic                  reload_ok;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (state_q == RUN),
    .tick   (tick)
  );

  assign reload_ok = bus.auto_reload && (reload_q != '0);

  // State register plus all registered datapath/outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      expired_q <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_next;
      count_q   <= count_next;
      reload_q  <= reload_next;
      expired_q <= expired_next;
      running_q <= running_next;
      done_q    <= done_next;
    end
  end

  // Next state: load > stop > start > tick; stop also masks start and tick
  always_comb begin
    state_next = state_q;
    if (bus.load) begin
      state_next = IDLE;
    end else if (bus.stop) begin
      if (state_q == RUN) state_next = PAUSE;
    end else begin
      if (bus.start && can_start(state_q) && (count_q != '0)) begin
        state_next = RUN;
      end
      if (tick && (count_q == ONE) && !reload_ok) begin
        state_next = DONE;
      end
    end
  end

  // Datapath and output next values
  always_comb begin
    count_next   = count_q;
    reload_next  = reload_q;
    expired_next = 1'b0;
    if (bus.load) begin
      count_next  = bus.load_value;
      reload_next = bus.load_value;
    end else if (!bus.stop && tick && (count_q != '0)) begin
      if (count_q == ONE) begin
        expired_next = 1'b1;
        count_next   = reload_ok ? reload_q : '0;
      end else begin
        count_next = count_q - ONE;
      end
    end
    running_next = (state_next == RUN);
    done_next    = (state_next == DONE);
  end

  assign bus.count   = count_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;
  assign bus.expired = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: vector table on a PRESCALE=1 instance, sequences on PRESCALE=4.
module tb_countdown_timer;

  localparam int unsigned W = 16;
  localparam int unsigned NVEC = 48;

  typedef struct {
    logic         rst;
    logic         ld;
    logic [W-1:0] lv;
    logic         st;
    logic         sp;
    logic         ar;
    logic [W-1:0] e_cnt;
    logic         e_run;
    logic         e_done;
    logic         e_exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset1;
  logic reset2;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  countdown_timer_if #(.DATA_WIDTH(W)) bus1 ();
  countdown_timer_if #(.DATA_WIDTH(W)) bus2 ();

  countdown_timer #(.DATA_WIDTH(W), .PRESCALE(1)) u_dut1 (
    .clk   (clk),
    .reset (reset1),
    .bus   (bus1)
  );

  countdown_timer #(.DATA_WIDTH(W), .PRESCALE(4)) u_dut2 (
    .clk   (clk),
    .reset (reset2),
    .bus   (bus2)
  );

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0d expected=%0d", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(logic rst, logic ld, int lv, logic st, logic sp, logic ar,
                              int e_cnt, logic e_run, logic e_done, logic e_exp);
    vec_t v;
    v.rst = rst; v.ld = ld; v.lv = W'(lv); v.st = st; v.sp = sp; v.ar = ar;
    v.e_cnt = W'(e_cnt); v.e_run = e_run; v.e_done = e_done; v.e_exp = e_exp;
    return v;
  endfunction

  task automatic apply1(input vec_t v, input int idx);
    @(negedge clk);
    reset1           = v.rst;
    bus1.load        = v.ld;
    bus1.load_value  = v.lv;
    bus1.start       = v.st;
    bus1.stop        = v.sp;
    bus1.auto_reload = v.ar;
    @(posedge clk);
    #1;
    check("p1_count",   idx, 32'(bus1.count),   32'(v.e_cnt));
    check("p1_running", idx, 32'(bus1.running), 32'(v.e_run));
    check("p1_done",    idx, 32'(bus1.done),    32'(v.e_done));
    check("p1_expired", idx, 32'(bus1.expired), 32'(v.e_exp));
  endtask

  task automatic step2(input logic ld, input int lv, input logic st, input logic sp);
    @(negedge clk);
    bus2.load       = ld;
    bus2.load_value = W'(lv);
    bus2.start      = st;
    bus2.stop       = sp;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[NVEC];

  initial begin
    // load 5, count to expiry, start in DONE ignored
    vecs[0]  = mk(0, 1, 5, 0, 0, 0,  5, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 1, 0, 0,  5, 1, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0,  4, 1, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0,  3, 1, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0,  2, 1, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0,  1, 1, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 1);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 0);
    vecs[8]  = mk(0, 0, 0, 1, 0, 0,  0, 0, 1, 0);
    // auto-reload period 3, then let it expire with auto_reload low
    vecs[9]  = mk(0, 1, 3, 0, 0, 1,  3, 0, 0, 0);
    vecs[10] = mk(0, 0, 0, 1, 0, 1,  3, 1, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 0, 1,  2, 1, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 0, 1,  1, 1, 0, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 1,  3, 1, 0, 1);
    vecs[14] = mk(0, 0, 0, 0, 0, 1,  2, 1, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, 0, 1,  1, 1, 0, 0);
    vecs[16] = mk(0, 0, 0, 0, 0, 1,  3, 1, 0, 1);
    vecs[17] = mk(0, 0, 0, 0, 0, 0,  2, 1, 0, 0);
    vecs[18] = mk(0, 0, 0, 0, 0, 0,  1, 1, 0, 0);
    vecs[19] = mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 1);
    // pause/resume, stop+start together
    vecs[20] = mk(0, 1, 10, 0, 0, 0, 10, 0, 0, 0);
    vecs[21] = mk(0, 0, 0, 1, 0, 0, 10, 1, 0, 0);
    vecs[22] = mk(0, 0, 0, 0, 0, 0,  9, 1, 0, 0);
    vecs[23] = mk(0, 0, 0, 0, 0, 0,  8, 1, 0, 0);
    vecs[24] = mk(0, 0, 0, 0, 0, 0,  7, 1, 0, 0);
    vecs[25] = mk(0, 0, 0, 0, 1, 0,  7, 0, 0, 0);
    vecs[26] = mk(0, 0, 0, 0, 0, 0,  7, 0, 0, 0);
    vecs[27] = mk(0, 0, 0, 1, 0, 0,  7, 1, 0, 0);
    vecs[28] = mk(0, 0, 0, 0, 0, 0,  6, 1, 0, 0);
    vecs[29] = mk(0, 0, 0, 1, 1, 0,  6, 0, 0, 0);
    vecs[30] = mk(0, 0, 0, 1, 0, 0,  6, 1, 0, 0);
    vecs[31] = mk(0, 0, 0, 1, 0, 0,  5, 1, 0, 0);
    // zero load, load+start same cycle
    vecs[32] = mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 0);
    vecs[33] = mk(0, 0, 0, 1, 0, 0,  0, 0, 0, 0);
    vecs[34] = mk(0, 1, 4, 1, 0, 0,  4, 0, 0, 0);
    vecs[35] = mk(0, 0, 0, 0, 0, 0,  4, 0, 0, 0);
    // reset at count 1 discards the pending expiry
    vecs[36] = mk(0, 0, 0, 1, 0, 0,  4, 1, 0, 0);
    vecs[37] = mk(0, 0, 0, 0, 0, 0,  3, 1, 0, 0);
    vecs[38] = mk(0, 0, 0, 0, 0, 0,  2, 1, 0, 0);
    vecs[39] = mk(0, 0, 0, 0, 0, 0,  1, 1, 0, 0);
    vecs[40] = mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    vecs[41] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    // load while running returns to IDLE; stop outranks start in IDLE
    vecs[42] = mk(0, 1, 2, 0, 0, 0,  2, 0, 0, 0);
    vecs[43] = mk(0, 0, 0, 1, 0, 0,  2, 1, 0, 0);
    vecs[44] = mk(0, 1, 7, 0, 0, 0,  7, 0, 0, 0);
    vecs[45] = mk(0, 0, 0, 0, 0, 0,  7, 0, 0, 0);
    vecs[46] = mk(0, 0, 0, 1, 1, 0,  7, 0, 0, 0);
    vecs[47] = mk(0, 0, 0, 1, 0, 0,  7, 1, 0, 0);

    reset1 = 1'b1; reset2 = 1'b1;
    bus1.load = 1'b0; bus1.load_value = '0; bus1.start = 1'b0; bus1.stop = 1'b0; bus1.auto_reload = 1'b0;
    bus2.load = 1'b0; bus2.load_value = '0; bus2.start = 1'b0; bus2.stop = 1'b0; bus2.auto_reload = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count",   0, 32'(bus1.count),   0);
    check("rst_running", 0, 32'(bus1.running), 0);
    check("rst_done",    0, 32'(bus1.done),    0);
    check("rst_expired", 0, 32'(bus1.expired), 0);
    @(negedge clk);
    reset1 = 1'b0; reset2 = 1'b0;

    for (int i = 0; i < int'(NVEC); i++) apply1(vecs[i], i);

    // PRESCALE=4: first decrement 4 edges after start, expiry at edge 8
    step2(1'b1, 2, 1'b0, 1'b0);
    check("p4_load_count", 0, 32'(bus2.count), 2);
    step2(1'b0, 0, 1'b1, 1'b0);
    check("p4_start_running", 0, 32'(bus2.running), 1);
    for (int e = 1; e <= 8; e++) begin
      step2(1'b0, 0, 1'b0, 1'b0);
      check("p4_count",   e, 32'(bus2.count),   (e < 4) ? 2 : (e < 8) ? 1 : 0);
      check("p4_expired", e, 32'(bus2.expired), (e == 8) ? 1 : 0);
    end
    check("p4_done",    8, 32'(bus2.done),    1);
    check("p4_running", 8, 32'(bus2.running), 0);

    // PRESCALE=4: a pause restarts the prescaler phase
    step2(1'b1, 3, 1'b0, 1'b0);
    step2(1'b0, 0, 1'b1, 1'b0);
    step2(1'b0, 0, 1'b0, 1'b0);
    step2(1'b0, 0, 1'b0, 1'b1);
    check("p4_pause_running", 2, 32'(bus2.running), 0);
    check("p4_pause_count",   2, 32'(bus2.count),   3);
    step2(1'b0, 0, 1'b1, 1'b0);
    check("p4_resume_running", 3, 32'(bus2.running), 1);
    for (int e = 4; e <= 7; e++) begin
      step2(1'b0, 0, 1'b0, 1'b0);
      check("p4_resume_count", e, 32'(bus2.count), (e < 7) ? 3 : 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
